// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage and the control FSM:
// read-protocol sub-stages, reset fetch address and opcode byte values.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    SUB_SET_ADDR = 2'd0,
    SUB_WAIT     = 2'd1,
    SUB_CAPTURE  = 2'd2
  } sub_e;

  localparam logic [15:0] DEFAULT_RESET_PC = 16'h1000;

  // Two-byte instructions (immediate / zero-page / relative)
  localparam logic [7:0] OP_LDA_IMM = 8'hA9;
  localparam logic [7:0] OP_LDA_ZP  = 8'hA5;
  localparam logic [7:0] OP_STA_ZP  = 8'h85;
  localparam logic [7:0] OP_ADC_IMM = 8'h69;
  localparam logic [7:0] OP_SBC_IMM = 8'hE9;
  localparam logic [7:0] OP_AND_IMM = 8'h29;
  localparam logic [7:0] OP_ORA_IMM = 8'h09;
  localparam logic [7:0] OP_EOR_IMM = 8'h49;
  localparam logic [7:0] OP_INC_ZP  = 8'hE6;
  localparam logic [7:0] OP_BEQ     = 8'hF0;
  localparam logic [7:0] OP_BNE     = 8'hD0;

  // Three-byte instructions (absolute)
  localparam logic [7:0] OP_LDA_ABS = 8'hAD;
  localparam logic [7:0] OP_STA_ABS = 8'h8D;
  localparam logic [7:0] OP_JMP_ABS = 8'h4C;

  // One-byte instructions (implied / accumulator)
  localparam logic [7:0] OP_INX     = 8'hE8;
  localparam logic [7:0] OP_ASL_A   = 8'h0A;
  localparam logic [7:0] OP_LSR_A   = 8'h4A;
  localparam logic [7:0] OP_ROL_A   = 8'h2A;
  localparam logic [7:0] OP_ROR_A   = 8'h6A;

endpackage

// File: rtl/fetch_unit_instr_length.sv
// Opcode to instruction length lookup, shared by fetch and decode so the
// two can never disagree on instruction boundaries.
module instr_length
  import fetch_unit_pkg::*;
(
  input  logic [7:0] opcode,
  output logic [1:0] size
);

  // Length table; anything not listed is a single-byte instruction
  always_comb begin
    size = 2'd1;
    case (opcode)
      OP_LDA_IMM, OP_LDA_ZP, OP_STA_ZP, OP_ADC_IMM, OP_SBC_IMM,
      OP_AND_IMM, OP_ORA_IMM, OP_EOR_IMM, OP_INC_ZP, OP_BEQ,
      OP_BNE:                               size = 2'd2;
      OP_LDA_ABS, OP_STA_ABS, OP_JMP_ABS:   size = 2'd3;
      default:                              size = 2'd1;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: walks fetch_pc through the shared RAM with the
// three-cycle SET_ADDR/WAIT/CAPTURE read, assembles opcode plus operands and
// holds the finished instruction until the consumer takes it.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [15:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] ram_address,
  output logic        r_ram,
  input  logic [7:0]  ram_data_out,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [7:0]  opcode,
  output logic [7:0]  operand_lo,
  output logic [7:0]  operand_hi,
  output logic [1:0]  instr_size,
  output logic [15:0] instr_pc,
  input  logic        redirect,
  input  logic [15:0] redirect_pc
);

  sub_e        sub_q, sub_d;
  logic [15:0] fetch_pc_q, fetch_pc_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic        hold_q, hold_d;
  logic [7:0]  opcode_q, opcode_d;
  logic [7:0]  operand_lo_q, operand_lo_d;
  logic [7:0]  operand_hi_q, operand_hi_d;
  logic [1:0]  instr_size_q, instr_size_d;
  logic [15:0] instr_pc_q, instr_pc_d;

  logic [1:0]  len_size;
  logic [1:0]  cur_size;

  instr_length u_instr_length (
    .opcode (ram_data_out),
    .size   (len_size)
  );

  // Next-state: redirect overrides hold and any in-flight byte fetch
  always_comb begin
    sub_d        = sub_q;
    fetch_pc_d   = fetch_pc_q;
    byte_idx_d   = byte_idx_q;
    hold_d       = hold_q;
    opcode_d     = opcode_q;
    operand_lo_d = operand_lo_q;
    operand_hi_d = operand_hi_q;
    instr_size_d = instr_size_q;
    instr_pc_d   = instr_pc_q;
    // On the opcode byte the length comes straight from the table, since
    // instr_size_q is only updated at the end of this cycle.
    cur_size     = (byte_idx_q == 2'd0) ? len_size : instr_size_q;

    if (redirect) begin
      fetch_pc_d = redirect_pc;
      byte_idx_d = '0;
      sub_d      = SUB_SET_ADDR;
      hold_d     = 1'b0;
    end else if (hold_q) begin
      if (instr_ready) begin
        hold_d     = 1'b0;
        byte_idx_d = '0;
        sub_d      = SUB_SET_ADDR;
      end
    end else begin
      case (sub_q)
        SUB_SET_ADDR: sub_d = SUB_WAIT;
        SUB_WAIT:     sub_d = SUB_CAPTURE;
        SUB_CAPTURE: begin
          fetch_pc_d = fetch_pc_q + 16'd1;
          sub_d      = SUB_SET_ADDR;
          case (byte_idx_q)
            2'd0: begin
              opcode_d     = ram_data_out;
              instr_pc_d   = fetch_pc_q;
              instr_size_d = len_size;
              operand_lo_d = '0;
              operand_hi_d = '0;
            end
            2'd1:    operand_lo_d = ram_data_out;
            default: operand_hi_d = ram_data_out;
          endcase
          if (byte_idx_q + 2'd1 == cur_size) begin
            hold_d = 1'b1;
          end else begin
            byte_idx_d = byte_idx_q + 2'd1;
          end
        end
        default: sub_d = SUB_SET_ADDR;
      endcase
    end
  end

  // State and payload registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      sub_q        <= SUB_SET_ADDR;
      fetch_pc_q   <= RESET_PC;
      byte_idx_q   <= '0;
      hold_q       <= 1'b0;
      opcode_q     <= '0;
      operand_lo_q <= '0;
      operand_hi_q <= '0;
      instr_size_q <= '0;
      instr_pc_q   <= '0;
    end else begin
      sub_q        <= sub_d;
      fetch_pc_q   <= fetch_pc_d;
      byte_idx_q   <= byte_idx_d;
      hold_q       <= hold_d;
      opcode_q     <= opcode_d;
      operand_lo_q <= operand_lo_d;
      operand_hi_q <= operand_hi_d;
      instr_size_q <= instr_size_d;
      instr_pc_q   <= instr_pc_d;
    end
  end

  // RAM read request only during address/wait phases of an active fetch
  always_comb begin
    r_ram       = !reset && !hold_q && (sub_q != SUB_CAPTURE);
    ram_address = r_ram ? fetch_pc_q : '0;
    instr_valid = hold_q;
    opcode      = opcode_q;
    operand_lo  = operand_lo_q;
    operand_hi  = operand_hi_q;
    instr_size  = instr_size_q;
    instr_pc    = instr_pc_q;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: a RAM model, a cycle-level reference of
// the fetch timeline, and a scoreboard of expected instructions.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] ram_address;
  logic        r_ram;
  logic [7:0]  ram_data_out = '0;
  logic        instr_valid;
  logic        instr_ready;
  logic [7:0]  opcode, operand_lo, operand_hi;
  logic [1:0]  instr_size;
  logic [15:0] instr_pc;
  logic        redirect;
  logic [15:0] redirect_pc;

  typedef struct {
    logic [15:0] pc;
    logic [7:0]  op;
    logic [7:0]  lo;
    logic [7:0]  hi;
    logic [1:0]  size;
  } instr_t;

  logic [7:0] mem [0:65535];
  instr_t     exp_q[$];
  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  fetch_unit #(.RESET_PC(16'h1000)) dut (
    .clk(clk), .reset(reset), .ram_address(ram_address), .r_ram(r_ram),
    .ram_data_out(ram_data_out), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .opcode(opcode), .operand_lo(operand_lo),
    .operand_hi(operand_hi), .instr_size(instr_size), .instr_pc(instr_pc),
    .redirect(redirect), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  // Synchronous-read RAM: data presented the cycle after a read request
  always @(posedge clk) if (r_ram) ram_data_out <= mem[ram_address];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int ref_len(input logic [7:0] op);
    if (op inside {8'hA9, 8'hA5, 8'h85, 8'h69, 8'hE9, 8'h29, 8'h09, 8'h49, 8'hE6, 8'hF0, 8'hD0})
      return 2;
    if (op inside {8'hAD, 8'h8D, 8'h4C})
      return 3;
    return 1;
  endfunction

  function automatic instr_t ref_instr(input logic [15:0] pc);
    instr_t t;
    int n;
    n      = ref_len(mem[pc]);
    t.pc   = pc;
    t.op   = mem[pc];
    t.size = 2'(n);
    t.lo   = (n >= 2) ? mem[16'(pc + 16'd1)] : 8'h00;
    t.hi   = (n == 3) ? mem[16'(pc + 16'd2)] : 8'h00;
    return t;
  endfunction

  // Reference timeline: a fetch of N bytes begun at m_start at m_pc
  int          cyc = 0;
  int          m_start = 0;
  int          m_size = 1;
  logic [15:0] m_pc = '0;
  logic        prev_reset = 1'b0;

  task automatic restart(input int at, input logic [15:0] pc);
    m_start = at;
    m_pc    = pc;
    m_size  = ref_len(mem[pc]);
    exp_q.delete();
    exp_q.push_back(ref_instr(pc));
  endtask

  // Scoreboard monitor: compare presented instruction, pop when it leaves
  always begin
    @(negedge clk);
    if (!reset && instr_valid) begin
      if (exp_q.size() == 0) begin
        chk("sb_empty", 32'd0, 32'd1);
      end else begin
        chk("opcode",     {24'd0, opcode},     {24'd0, exp_q[0].op});
        chk("operand_lo", {24'd0, operand_lo}, {24'd0, exp_q[0].lo});
        chk("operand_hi", {24'd0, operand_hi}, {24'd0, exp_q[0].hi});
        chk("instr_size", {30'd0, instr_size}, {30'd0, exp_q[0].size});
        chk("instr_pc",   {16'd0, instr_pc},   {16'd0, exp_q[0].pc});
        if (instr_ready || redirect) void'(exp_q.pop_front());
      end
    end
  end

  // Cycle-level reference: bus activity and valid timing, then event update
  always begin
    int k, ph, b;
    @(negedge clk);
    #2;
    if (reset) begin
      chk("rst_r_ram", {31'd0, r_ram}, 32'd0);
      chk("rst_addr",  {16'd0, ram_address}, 32'd0);
      if (prev_reset) begin
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_payload", {opcode, operand_lo, operand_hi, 6'd0, instr_size},
            32'd0);
        chk("rst_pc", {16'd0, instr_pc}, 32'd0);
      end
      restart(cyc + 1, 16'h1000);
    end else begin
      k = cyc - m_start;
      if (k < 3 * m_size) begin
        ph = k % 3;
        b  = k / 3;
        chk("early_valid", {31'd0, instr_valid}, 32'd0);
        if (ph < 2) begin
          chk("fetch_r_ram", {31'd0, r_ram}, 32'd1);
          chk("fetch_addr",  {16'd0, ram_address}, {16'd0, 16'(m_pc + 16'(b))});
        end else begin
          chk("capture_r_ram", {31'd0, r_ram}, 32'd0);
          chk("capture_addr",  {16'd0, ram_address}, 32'd0);
        end
      end else begin
        chk("hold_valid", {31'd0, instr_valid}, 32'd1);
        chk("hold_r_ram", {31'd0, r_ram}, 32'd0);
        chk("hold_addr",  {16'd0, ram_address}, 32'd0);
      end
      if (redirect)
        restart(cyc + 1, redirect_pc);
      else if (k >= 3 * m_size && instr_ready)
        restart(cyc + 1, 16'(m_pc + 16'(m_size)));
    end
    prev_reset = reset;
    cyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string nm);
    for (int i = 0; i < 40; i++) begin
      if (instr_valid) return;
      step();
    end
    chk(nm, 32'd0, 32'd1);
  endtask

  task automatic wait_read(input logic [15:0] a, input string nm);
    for (int i = 0; i < 40; i++) begin
      if (r_ram && ram_address == a) return;
      step();
    end
    chk(nm, 32'd0, 32'd1);
  endtask

  task automatic do_redirect(input logic [15:0] pc);
    redirect    = 1'b1;
    redirect_pc = pc;
    step();
    redirect    = 1'b0;
  endtask

  logic [7:0] op_list [19] = '{8'hA9, 8'hA5, 8'h85, 8'h69, 8'hE9, 8'h29, 8'h09,
                               8'h49, 8'hE6, 8'hF0, 8'hD0, 8'hAD, 8'h8D, 8'h4C,
                               8'hE8, 8'h0A, 8'h4A, 8'h2A, 8'h6A};

  initial begin
    int rst_left;
    for (int i = 0; i < 65536; i++)
      mem[i] = ($urandom_range(0, 1) == 0) ? op_list[$urandom_range(0, 18)]
                                           : 8'($urandom);
    mem[16'h1000] = 8'hE8;
    mem[16'h1001] = 8'hAD; mem[16'h1002] = 8'h34; mem[16'h1003] = 8'h12;
    mem[16'h1004] = 8'hA9; mem[16'h1005] = 8'h55;
    mem[16'h3000] = 8'hAD; mem[16'h3001] = 8'h11; mem[16'h3002] = 8'h22;
    mem[16'h2000] = 8'h4A;
    mem[16'hFFFF] = 8'hA9; mem[16'h0000] = 8'h77;

    reset = 1'b1; instr_ready = 1'b1; redirect = 1'b0; redirect_pc = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Single-byte then three-byte instruction, then stall the two-byte one
    wait_read(16'h1004, "to_1004");
    instr_ready = 1'b0;
    wait_valid("valid_a9");
    repeat (6) step();
    instr_ready = 1'b1;
    step();

    // Redirect during WAIT of the high operand byte
    do_redirect(16'h3000);
    wait_read(16'h3002, "to_3002");
    step();
    do_redirect(16'h2000);
    wait_valid("valid_2000");

    // PC wrap across FFFF
    do_redirect(16'hFFFF);
    wait_valid("valid_ffff");
    step();

    // Redirect coinciding with accept
    instr_ready = 1'b0;
    wait_valid("valid_pre_rr");
    instr_ready = 1'b1;
    do_redirect(16'h2000);

    // Randomized traffic with occasional redirects and resets
    rst_left = 0;
    for (int i = 0; i < 4000; i++) begin
      if (rst_left == 0 && $urandom_range(0, 299) == 0) rst_left = $urandom_range(1, 3);
      reset       = (rst_left != 0);
      if (rst_left != 0) rst_left--;
      redirect    = !reset && ($urandom_range(0, 39) == 0);
      redirect_pc = 16'($urandom);
      instr_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    reset = 1'b0; redirect = 1'b0;
    repeat (4) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
